// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types, frame constants and parity helper for the PS/2 receiver
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_t;

  localparam int   FRAME_DATA_BITS = 8;
  localparam logic PS2_START       = 1'b0;
  localparam logic PS2_STOP        = 1'b1;

  // PS/2 uses odd parity: the eight data bits plus the parity bit hold an odd number of ones
  function automatic logic odd_parity_ok(input logic [FRAME_DATA_BITS-1:0] data, input logic p);
    return (^data) ^ p;
  endfunction

endpackage

// File: rtl/ps2_rx_frontend.sv
// rtl/ps2_rx_frontend.sv - PS/2 input synchronisers, clock glitch filter and falling-edge strobe
module ps2_rx_frontend #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fe,
  output logic data_bit
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;

  logic          clk_meta, clk_sync;
  logic          data_meta, data_sync;
  logic          filt_q;
  logic [FW-1:0] run_q;

  // Two-flop synchronisers; reset to the idle-high bus level so reset release looks quiet
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk;
      clk_sync  <= clk_meta;
      data_meta <= ps2_data;
      data_sync <= data_meta;
    end
  end

  // Accept a new clock level only after FILTER_LEN consecutive differing samples; emit fe on 1->0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q   <= 1'b1;
      run_q    <= '0;
      fe       <= 1'b0;
      data_bit <= 1'b1;
    end else begin
      fe <= 1'b0;
      if (clk_sync == filt_q) begin
        run_q <= '0;
      end else if (run_q == FW'(FILTER_LEN - 1)) begin
        filt_q <= clk_sync;
        run_q  <= '0;
        if (!clk_sync) begin
          fe       <= 1'b1;
          data_bit <= data_sync;
        end
      end else begin
        run_q <= run_q + FW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 frame receiver with checked frames buffered in a FWFT FIFO
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 4096,
  parameter int KEEP_BAD   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ps2_clk,
  input  logic                   ps2_data,
  input  logic                   read,
  input  logic                   clear_err,
  output logic                   ready,
  output logic                   full,
  output logic [7:0]             key_out,
  output logic [$clog2(DEPTH):0] count,
  output logic                   parity_err,
  output logic                   frame_err,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  logic                       fe, rx_bit;
  rx_state_t                  state, state_nxt;
  logic [2:0]                 bit_idx;
  logic [FRAME_DATA_BITS-1:0] shift_q;
  logic                       par_q;
  logic [TW-1:0]              timer;
  logic                       tmo;
  logic                       push_d, set_frame, set_par;
  logic                       push_q;
  logic [7:0]                 push_byte_q;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt_q;
  logic [7:0]    last_q;
  logic          pop, do_write;

  ps2_rx_frontend #(.FILTER_LEN(FILTER_LEN)) u_frontend (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .fe       (fe),
    .data_bit (rx_bit)
  );

  assign tmo = (state != ST_IDLE) && !fe && (timer == TW'(TIMEOUT - 1));

  // Receiver state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Receiver next-state: advance one field per fe, timeout drops a partial frame
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (fe && rx_bit == PS2_START) state_nxt = ST_DATA;
      ST_DATA:   if (tmo) state_nxt = ST_IDLE;
                 else if (fe && bit_idx == 3'(FRAME_DATA_BITS - 1)) state_nxt = ST_PARITY;
      ST_PARITY: if (tmo) state_nxt = ST_IDLE;
                 else if (fe) state_nxt = ST_STOP;
      ST_STOP:   if (tmo || fe) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Receiver outputs: frame verdict at the stop-bit fe, error set requests
  always_comb begin
    set_frame = 1'b0;
    set_par   = 1'b0;
    push_d    = 1'b0;
    case (state)
      ST_IDLE: if (fe && rx_bit != PS2_START) set_frame = 1'b1;
      ST_STOP: if (fe) begin
        if (rx_bit != PS2_STOP) begin
          set_frame = 1'b1;
        end else if (!odd_parity_ok(shift_q, par_q)) begin
          set_par = 1'b1;
          push_d  = (KEEP_BAD != 0);
        end else begin
          push_d = 1'b1;
        end
      end
      default: ;
    endcase
    if (tmo) set_frame = 1'b1;
  end

  // Frame datapath: bit counter, LSB-first shifter, parity capture, inactivity timer, push register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_idx     <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      timer       <= '0;
      push_q      <= 1'b0;
      push_byte_q <= '0;
    end else begin
      if (fe) begin
        case (state)
          ST_IDLE:   bit_idx <= '0;
          ST_DATA:   begin
            shift_q <= {rx_bit, shift_q[FRAME_DATA_BITS-1:1]};
            bit_idx <= bit_idx + 3'd1;
          end
          ST_PARITY: par_q <= rx_bit;
          default: ;
        endcase
      end
      if (fe || state == ST_IDLE) timer <= '0;
      else                        timer <= timer + TW'(1);
      push_q      <= push_d;
      push_byte_q <= shift_q;
    end
  end

  assign pop      = read && ready;
  assign do_write = push_q && (!full || pop);

  // FIFO storage; when full with a pop, wr_ptr equals rd_ptr and the departing head slot is reused
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= push_byte_q;
  end

  // FIFO pointers, occupancy, and the last popped byte shown while empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        last_q <= mem[rd_ptr];
      end
      case ({do_write, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as clear_err wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      parity_err <= (parity_err && !clear_err) || set_par;
      frame_err  <= (frame_err && !clear_err) || set_frame;
      overflow   <= (overflow && !clear_err) || (push_q && full && !pop);
    end
  end

  assign count   = cnt_q;
  assign ready   = (cnt_q != '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign key_out = ready ? mem[rd_ptr] : last_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - directed self-checking bench for ps2_rx_fifo
module tb_ps2_rx_fifo;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 256;
  localparam int HALF    = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       read = 1'b0;
  logic       read_kb = 1'b0;
  logic       clear_err = 1'b0;

  logic       ready, full, parity_err, frame_err, overflow;
  logic [7:0] key_out;
  logic [2:0] count;
  logic       ready_kb, full_kb, parity_err_kb, frame_err_kb, overflow_kb;
  logic [7:0] key_out_kb;
  logic [2:0] count_kb;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ps2_rx_fifo #(.DEPTH(DEPTH), .FILTER_LEN(4), .TIMEOUT(TIMEOUT), .KEEP_BAD(0)) u_dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .read(read), .clear_err(clear_err),
    .ready(ready), .full(full), .key_out(key_out), .count(count),
    .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow)
  );

  ps2_rx_fifo #(.DEPTH(DEPTH), .FILTER_LEN(4), .TIMEOUT(TIMEOUT), .KEEP_BAD(1)) u_dut_kb (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .read(read_kb), .clear_err(clear_err),
    .ready(ready_kb), .full(full_kb), .key_out(key_out_kb), .count(count_kb),
    .parity_err(parity_err_kb), .frame_err(frame_err_kb), .overflow(overflow_kb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_read();
    read = 1'b1;
    cyc(1);
    read = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    cyc(1);
    clear_err = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(2);
  endtask

  // Send nbits of a frame (11 = complete); optional bad parity, bad stop, clock glitches, push-latency probe
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop_bit,
                            input int nbits, input bit glitch, input bit measure);
    logic [10:0] fr;
    bit got;
    fr = {stop_bit, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      cyc(HALF);
      if (glitch && i == 4) begin
        ps2_clk = 1'b0; cyc(1); ps2_clk = 1'b1; cyc(3);
        ps2_clk = 1'b0; cyc(2); ps2_clk = 1'b1; cyc(4);
      end
      ps2_clk = 1'b0;
      if (measure && i == 10) begin
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
          @(negedge clk);
          if (u_dut.fe) got = 1'b1;
        end
        chk("stop_fe_seen", 32'(got), 32'd1);
        chk("lat_fe_cycle_ready", 32'(ready), 32'd0);
        @(negedge clk);
        chk("lat_plus1_ready", 32'(ready), 32'd0);
        @(negedge clk);
        chk("lat_plus2_ready", 32'(ready), 32'd1);
        chk("lat_plus2_key", 32'(key_out), 32'h4B);
      end
      cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    cyc(HALF);
  endtask

  initial begin
    // reset state
    cyc(3);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_key", 32'(key_out), 32'h00);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_flags", 32'({parity_err, frame_err, overflow}), 32'd0);
    rst = 1'b0;
    cyc(2);

    // single frame with push-latency probe, then pop
    send_frame(8'h4B, 1'b0, 1'b1, 11, 1'b0, 1'b1);
    chk("f1_key", 32'(key_out), 32'h4B);
    chk("f1_ready", 32'(ready), 32'd1);
    chk("f1_count", 32'(count), 32'd1);
    chk("f1_flags", 32'({parity_err, frame_err, overflow}), 32'd0);
    pulse_read();
    chk("f1_pop_ready", 32'(ready), 32'd0);
    chk("f1_pop_count", 32'(count), 32'd0);
    chk("f1_pop_key_hold", 32'(key_out), 32'h4B);

    // three back-to-back frames drained in order
    send_frame(8'h4B, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    send_frame(8'h32, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    chk("b3_count3", 32'(count), 32'd3);
    chk("b3_key0", 32'(key_out), 32'h4B);
    pulse_read();
    chk("b3_count2", 32'(count), 32'd2);
    chk("b3_key1", 32'(key_out), 32'h1C);
    pulse_read();
    chk("b3_count1", 32'(count), 32'd1);
    chk("b3_key2", 32'(key_out), 32'h32);
    pulse_read();
    chk("b3_count0", 32'(count), 32'd0);
    chk("b3_ready0", 32'(ready), 32'd0);

    // fill to DEPTH, then one more for overflow
    send_frame(8'h11, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    send_frame(8'h33, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    chk("fill3_full", 32'(full), 32'd0);
    send_frame(8'h44, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    chk("fill4_full", 32'(full), 32'd1);
    chk("fill4_ovf", 32'(overflow), 32'd0);
    send_frame(8'h55, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd4);
    chk("ovf_key", 32'(key_out), 32'h11);
    pulse_clear();
    chk("ovf_cleared", 32'(overflow), 32'd0);
    pulse_read();
    chk("ovf_pop_key", 32'(key_out), 32'h22);
    chk("ovf_pop_count", 32'(count), 32'd3);
    chk("ovf_pop_full", 32'(full), 32'd0);
    pulse_read(); pulse_read();
    chk("ovf_tail_key", 32'(key_out), 32'h44);
    pulse_read();
    chk("ovf_drained", 32'(count), 32'd0);

    // bad parity: dropped with KEEP_BAD=0, kept with KEEP_BAD=1
    do_reset();
    send_frame(8'h4B, 1'b1, 1'b1, 11, 1'b0, 1'b0);
    chk("par_flag", 32'(parity_err), 32'd1);
    chk("par_count", 32'(count), 32'd0);
    chk("par_frame", 32'(frame_err), 32'd0);
    chk("par_kb_flag", 32'(parity_err_kb), 32'd1);
    chk("par_kb_count", 32'(count_kb), 32'd1);
    chk("par_kb_key", 32'(key_out_kb), 32'h4B);
    pulse_clear();
    chk("par_cleared", 32'(parity_err), 32'd0);

    // bad stop bit
    send_frame(8'h4B, 1'b0, 1'b0, 11, 1'b0, 1'b0);
    chk("stop_frame", 32'(frame_err), 32'd1);
    chk("stop_parity", 32'(parity_err), 32'd0);
    chk("stop_count", 32'(count), 32'd0);
    pulse_clear();
    chk("stop_cleared", 32'(frame_err), 32'd0);

    // partial frame aborted by timeout, then a clean frame
    send_frame(8'h4B, 1'b0, 1'b1, 5, 1'b0, 1'b0);
    chk("tmo_before", 32'(frame_err), 32'd0);
    cyc(TIMEOUT + 10);
    chk("tmo_frame", 32'(frame_err), 32'd1);
    chk("tmo_count", 32'(count), 32'd0);
    pulse_clear();
    send_frame(8'h4B, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    chk("tmo_next_key", 32'(key_out), 32'h4B);
    chk("tmo_next_count", 32'(count), 32'd1);
    chk("tmo_next_flags", 32'({parity_err, frame_err, overflow}), 32'd0);

    // short glitches on ps2_clk mid-frame are filtered out
    do_reset();
    send_frame(8'h5A, 1'b0, 1'b1, 11, 1'b1, 1'b0);
    chk("glitch_key", 32'(key_out), 32'h5A);
    chk("glitch_count", 32'(count), 32'd1);
    chk("glitch_flags", 32'({parity_err, frame_err, overflow}), 32'd0);

    // reset mid-frame clears everything without an edge, receiver restarts cleanly
    send_frame(8'h4B, 1'b0, 1'b1, 6, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    chk("rstmid_ready", 32'(ready), 32'd0);
    chk("rstmid_count", 32'(count), 32'd0);
    chk("rstmid_key", 32'(key_out), 32'h00);
    chk("rstmid_flags", 32'({parity_err, frame_err, overflow, full}), 32'd0);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(2);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    chk("rstmid_next_key", 32'(key_out), 32'h1C);
    chk("rstmid_next_count", 32'(count), 32'd1);
    chk("rstmid_next_flags", 32'({parity_err, frame_err, overflow}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
